mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed unified instruction/data memory that serves the multi-cycle MIPS core's memory accesses as the responder side of a request/ready handshake. The core presents the byte address selected by IorD, write data and a write strobe; this block captures the request, inserts a programmable number of wait states, commits writes, and returns read data with a one-cycle `ready` pulse. It sits between the datapath's address mux and the rest of the system, letting the control FSM stall on slow memory.

## Interface

Parameters:
- `DEPTH_WORDS`, 64: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-4.
- `WAIT_STATES`, 2: extra cycles between acceptance and response; legal range 0..15.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  1  access request; sampled only in IDLE.
- `we`  input  1  write strobe, qualified by `req`; 1 = write, 0 = read.
- `addr`  input  32  byte address of the access.
- `wd`  input  32  write data.
- `rd`  output  32  read data; valid while `ready`=1, held until the next response.
- `ready`  output  1  one-cycle response pulse.
- `err`  output  1  qualified by `ready`; 1 = access rejected.
- `busy`  output  1  1 whenever the FSM is not in IDLE.

## Operation

- FSM states: IDLE, WAIT, RESP. Wait counter `cnt`, 4 bits.
- IDLE: `busy`=0. If `req`=1 at a rising edge, capture `addr`, `we`, `wd` into internal registers (accepting edge). Requester may drop or change inputs after that edge.
  - Error check at acceptance: misaligned (`addr[1:0]` != 0) or out of range (`addr[31:2]` >= DEPTH_WORDS). On error: go to RESP with `err`=1, `rd` loaded with 0, no memory write.
  - Otherwise, WAIT_STATES=0: go directly to RESP, performing the access at the accepting edge. WAIT_STATES>0: go to WAIT, `cnt` loaded with WAIT_STATES-1.
- WAIT: `cnt` decrements each edge; at the edge where `cnt`=0, perform the access and go to RESP. Error requests never pass through WAIT.
- Access: write stores captured `wd` at word index `addr[31:2]`, leaves `rd` unchanged; read loads `rd` from the array at that index.
- RESP: `ready`=1 for exactly this cycle; next edge returns to IDLE unconditionally. `req` is ignored in WAIT and RESP (no queuing) and must be presented again in IDLE.
- `err` is updated only on entry to RESP: 1 for rejected, 0 for accepted.
- Array is not reset; uninitialized contents are X in simulation.

## Timing

- Reset (asynchronous, immediate): state IDLE, `cnt`=0, `ready`=0, `err`=0, `rd`=0, `busy`=0. Array contents unaffected.
- Reset mid-operation (WAIT or RESP): transaction aborted; an uncommitted write is dropped; no `ready` pulse follows.
- Latency: accepting edge at T; `ready` high in the cycle after edge T+WAIT_STATES (WAIT_STATES+1 cycles after acceptance). Errors: `ready` in the cycle after T regardless of WAIT_STATES.
- Write commits at the edge entering RESP; a read accepted in the following IDLE returns the new value.
- Minimum request spacing: WAIT_STATES+2 cycles (accept, waits, RESP, back to IDLE).
- `busy` rises in the cycle after acceptance and falls when the FSM returns to IDLE.

## Test plan

- WAIT_STATES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each access `ready` one cycle, 3 cycles after acceptance; read `rd`=0xDEADBEEF, `err`=0.
- Misaligned read at 0x13 and out-of-range write at 0x100 (DEPTH_WORDS=64) -> `ready` next cycle with `err`=1, `rd`=0; subsequent read of 0x00 unchanged.
- `req` held high continuously with changing `addr` during WAIT/RESP -> only the IDLE-sampled addresses are served, one response per WAIT_STATES+2 cycles.
- Assert `reset` during WAIT of a write of 0x12345678 to 0x20 (prior value 0xAAAAAAAA) -> no `ready`, outputs zero; later read of 0x20 returns 0xAAAAAAAA.
- WAIT_STATES=0: write 0x1 to 0x04, read 0x04 back-to-back -> each `ready` one cycle after acceptance, read `rd`=0x00000001, `busy` high exactly one cycle per access.
- Apply `reset` after a read returning 0x55 -> `rd`, `ready`, `err`, `busy` go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Word-addressed unified instruction/data memory acting as the
//                responder of a req/ready handshake for a multi-cycle MIPS
//                core. Captures a request in IDLE, waits WAIT_STATES cycles,
//                commits the access and pulses ready for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  // Word-index width; kept at least 1 bit so a single-word memory still builds.
  localparam int c_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [c_AW-1:0]   r_idx;
  logic              r_we;
  logic [31:0]       r_wd;
  logic [31:0]       r_rd;
  logic              r_ready;
  logic              r_err;

  // Storage is deliberately left unreset; only the handshake state is cleared.
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_req_err;
  logic [c_AW-1:0]   w_req_idx;
  logic              w_mem_we;
  logic [c_AW-1:0]   w_mem_idx;
  logic [31:0]       w_mem_wd;

  // Decode the incoming request: alignment/range check and word index.
  always_comb begin
    w_req_err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH_WORDS));
    w_req_idx = addr[c_AW+1:2];
  end

  // Write port control. With zero wait states the write happens on the
  // accepting edge straight from the inputs; otherwise it comes from the
  // captured request on the last WAIT edge. Reset blocks any commit so an
  // aborted write never lands in the array.
  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_idx = r_idx;
    w_mem_wd  = r_wd;
    if (r_state == S_IDLE) begin
      w_mem_idx = w_req_idx;
      w_mem_wd  = wd;
      w_mem_we  = (WAIT_STATES == 0) && req && we && !w_req_err;
    end else if (r_state == S_WAIT) begin
      w_mem_we  = (r_cnt == 4'd0) && r_we;
    end
    if (reset) begin
      w_mem_we = 1'b0;
    end
  end

  // Memory array write port.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wd;
    end
  end

  // Handshake FSM with registered rd/ready/err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wd    <= 32'd0;
      r_rd    <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_idx <= w_req_idx;
            r_we  <= we;
            r_wd  <= wd;
            if (w_req_err) begin
              // Rejected accesses skip the wait states entirely.
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rd    <= 32'd0;
            end else if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b0;
              if (!we) begin
                r_rd <= r_mem[w_req_idx];
              end
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            if (!r_we) begin
              r_rd <= r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // No queuing: any request seen here must be re-presented in IDLE.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd    = r_rd;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder with one instance at
//                WAIT_STATES=2 and one at WAIT_STATES=0; expected responses
//                are queued when a request is driven and popped on ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [31:0] addr2 = 32'd0, wd2 = 32'd0;
  logic [31:0] rd2;
  logic        ready2, err2, busy2;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wd0 = 32'd0;
  logic [31:0] rd0;
  logic        ready0, err0, busy0;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wd(wd2),
    .rd(rd2), .ready(ready2), .err(err2), .busy(busy2)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wd(wd0),
    .rd(rd0), .ready(ready0), .err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_rd(int d);
    return (d == 0) ? rd0 : rd2;
  endfunction
  function automatic logic f_ready(int d);
    return (d == 0) ? ready0 : ready2;
  endfunction
  function automatic logic f_err(int d);
    return (d == 0) ? err0 : err2;
  endfunction
  function automatic logic f_busy(int d);
    return (d == 0) ? busy0 : busy2;
  endfunction

  task automatic drive(int d, logic r, logic w, logic [31:0] a, logic [31:0] data);
    if (d == 0) begin
      req0 = r; we0 = w; addr0 = a; wd0 = data;
    end else begin
      req2 = r; we2 = w; addr2 = a; wd2 = data;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete transaction on instance d, starting from IDLE just after an edge.
  task automatic access(string tag, int d, logic [31:0] a, logic w, logic [31:0] data,
                        logic [31:0] erd, logic eerr, int elat);
    int   lat;
    exp_t e;
    drive(d, 1'b1, w, a, data);
    sb.push_back('{rd: erd, err: eerr});
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    check({tag, ".busy_acc"}, 32'(f_busy(d)), 32'd1);
    lat = 0;
    while (!f_ready(d) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    e = sb.pop_front();
    check({tag, ".rd"}, f_rd(d), e.rd);
    check({tag, ".err"}, 32'(f_err(d)), 32'(e.err));
    @(posedge clk); #1;
    check({tag, ".ready_drop"}, 32'(f_ready(d)), 32'd0);
    check({tag, ".busy_idle"}, 32'(f_busy(d)), 32'd0);
  endtask

  initial begin
    logic [31:0] addr_tab [1:8];
    exp_t        e;

    // Reset state of both instances.
    #2;
    check("rst.rd2",    rd2, 32'd0);
    check("rst.ready2", 32'(ready2), 32'd0);
    check("rst.err2",   32'(err2), 32'd0);
    check("rst.busy2",  32'(busy2), 32'd0);
    check("rst.rd0",    rd0, 32'd0);
    check("rst.busy0",  32'(busy0), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Basic write/read with two wait states.
    access("ws2.wr10", 2, 32'h10, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    access("ws2.rd10", 2, 32'h10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2);

    // Error responses: immediate, rd cleared, no array side effects.
    access("ws2.wr00", 2, 32'h00,  1'b1, 32'hCAFE0000, 32'hDEADBEEF, 1'b0, 2);
    access("ws2.mis",  2, 32'h13,  1'b0, 32'h0,        32'h0,        1'b1, 0);
    access("ws2.oor",  2, 32'h100, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
    access("ws2.rd00", 2, 32'h00,  1'b0, 32'h0,        32'hCAFE0000, 1'b0, 2);
    access("ws2.wr08", 2, 32'h08,  1'b1, 32'h11111111, 32'hCAFE0000, 1'b0, 2);

    // req held high with addr changing every cycle: only IDLE samples served.
    addr_tab[1] = 32'h0C; addr_tab[2] = 32'h14; addr_tab[3] = 32'h0C; addr_tab[4] = 32'h10;
    addr_tab[5] = 32'h0C; addr_tab[6] = 32'h08; addr_tab[7] = 32'h0C; addr_tab[8] = 32'h0C;
    drive(2, 1'b1, 1'b0, 32'h08, 32'h0);
    sb.push_back('{rd: 32'h11111111, err: 1'b0});
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold.ready.c%0d", c), 32'(ready2), 32'((c == 3) || (c == 7)));
      if (ready2 && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("hold.rd.c%0d", c), rd2, e.rd);
      end
      if (c == 8) begin
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      end else begin
        addr2 = addr_tab[c];
        if (c == 4) sb.push_back('{rd: 32'hDEADBEEF, err: 1'b0});
      end
    end
    check("hold.sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;

    // Reset during WAIT of a write: write dropped, no ready pulse.
    access("ws2.wr20", 2, 32'h20, 1'b1, 32'hAAAAAAAA, 32'hDEADBEEF, 1'b0, 2);
    drive(2, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    check("abort.busy_wait", 32'(busy2), 32'd1);
    reset = 1'b1;
    #1;
    check("abort.busy",  32'(busy2), 32'd0);
    check("abort.ready", 32'(ready2), 32'd0);
    check("abort.rd",    rd2, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort.no_ready.%0d", k), 32'(ready2), 32'd0);
    end
    access("ws2.rd20", 2, 32'h20, 1'b0, 32'h0, 32'hAAAAAAAA, 1'b0, 2);

    // Zero wait states: back-to-back accesses, one-cycle busy each.
    access("ws0.wr04", 0, 32'h04, 1'b1, 32'h00000001, 32'h0,        1'b0, 0);
    access("ws0.rd04", 0, 32'h04, 1'b0, 32'h0,        32'h00000001, 1'b0, 0);
    access("ws0.wr08", 0, 32'h08, 1'b1, 32'h00000055, 32'h00000001, 1'b0, 0);
    access("ws0.rd08", 0, 32'h08, 1'b0, 32'h0,        32'h00000055, 1'b0, 0);
    access("ws0.mis",  0, 32'h06, 1'b0, 32'h0,        32'h0,        1'b1, 0);

    // Asynchronous reset while a read of 0x55 is being returned.
    drive(0, 1'b1, 1'b0, 32'h08, 32'h0);
    sb.push_back('{rd: 32'h55, err: 1'b0});
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("arst.ready_pre", 32'(ready0), 32'd1);
    e = sb.pop_front();
    check("arst.rd_pre", rd0, e.rd);
    #1 reset = 1'b1;
    #1;
    check("arst.rd",    rd0, 32'd0);
    check("arst.ready", 32'(ready0), 32'd0);
    check("arst.err",   32'(err0), 32'd0);
    check("arst.busy",  32'(busy0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
